// File: rtl/add32_share_pkg.sv
// Shared types and constants for the add32_share_sched scheduler.
package add32_share_pkg;
  localparam int HALF_W = 16;
  localparam int OP_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;
endpackage

// File: rtl/add32_share_sched_rr_grant.sv
// Combinational round-robin picker: first asserted req at or above ptr, modulo NREQ.
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);
  int   cand;
  logic hit;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    hit     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand                = (int'(ptr) + k) % NREQ;
      hit                 = req[cand[IDW-1:0]] & ~gnt_any;
      gnt[cand[IDW-1:0]]  = hit;
      gnt_idx             = hit ? cand[IDW-1:0] : gnt_idx;
      gnt_any             = gnt_any | hit;
    end
  end
endmodule

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputed for carry-in 0 and 1.
module carry_select_adder_16bit
  import add32_share_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);
  logic [4:0] s0;
  logic [4:0] s1;
  logic       carry;

  // Ripple the block select signal through the precomputed block sums.
  always_comb begin
    carry = cin;
    sum   = '0;
    s0    = 5'd0;
    s1    = 5'd0;
    for (int blk = 0; blk < HALF_W / 4; blk++) begin
      s0 = {1'b0, a[blk*4 +: 4]} + {1'b0, b[blk*4 +: 4]};
      s1 = s0 + 5'd1;
      if (carry) begin
        sum[blk*4 +: 4] = s1[3:0];
        carry           = s1[4];
      end else begin
        sum[blk*4 +: 4] = s0[3:0];
        carry           = s0[4];
      end
    end
    cout = carry;
  end
endmodule

// File: rtl/add32_share_sched.sv
// Shares one 16-bit carry-select adder among NREQ requesters doing 32-bit adds in two passes.
// Define ADD32_SHARE_SAT_EN for unsigned saturation on carry out.
module add32_share_sched
  import add32_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OP_W-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_cout
);
  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              c16_q, c16_d, cout_q, cout_d, valid_q, valid_d;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;
  logic [OP_W-1:0]   sel_a, sel_b;
  logic [HALF_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  carry_select_adder_16bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One-hot AND-OR mux of the granted requester's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a = sel_a | (req_a[i*OP_W +: OP_W] & {OP_W{gnt[i]}});
      sel_b = sel_b | (req_b[i*OP_W +: OP_W] & {OP_W{gnt[i]}});
    end
  end

  // FSM next state, adder operand steering and datapath register updates.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    sum_d     = sum_q;
    c16_d     = c16_q;
    cout_d    = cout_q;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          req_ready = gnt;
          a_d       = sel_a;
          b_d       = sel_b;
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d   = ST_LO;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LO: begin
        add_a               = a_q[HALF_W-1:0];
        add_b               = b_q[HALF_W-1:0];
        add_cin             = 1'b0;
        sum_d[HALF_W-1:0]   = add_sum;
        c16_d               = add_cout;
        state_d             = ST_HI;
      end
      ST_HI: begin
        add_a   = a_q[OP_W-1:HALF_W];
        add_b   = b_q[OP_W-1:HALF_W];
        add_cin = c16_q;
`ifdef ADD32_SHARE_SAT_EN
        if (add_cout) begin
          sum_d = {OP_W{1'b1}};
        end else begin
          sum_d = {add_sum, sum_q[HALF_W-1:0]};
        end
`else
        sum_d   = {add_sum, sum_q[HALF_W-1:0]};
`endif
        cout_d  = add_cout;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_RSP);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      c16_q   <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      c16_q   <= c16_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = sum_q;
  assign rsp_id    = id_q;
  assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_add32_share_sched.sv
// Self-checking bench for add32_share_sched: directed table, corner sequences, randomized traffic.
module tb_add32_share_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADD32_SHARE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_cout;

  add32_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           cout;
  } rsp_t;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_cout;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  // Transaction-level reference: one op in flight, result due 3 cycles after grant.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_ptr  = 0;
  rsp_t        m_q[$];
  logic [31:0] op_a[NREQ];
  logic [31:0] op_b[NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t ref_add(input logic [31:0] a, input logic [31:0] b, input int id);
    rsp_t        r;
    logic [32:0] s;
    s      = {1'b0, a} + {1'b0, b};
    r.data = (SAT && s[32]) ? 32'hFFFF_FFFF : s[31:0];
    r.cout = s[32];
    r.id   = IDW'(id);
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      1:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_busy) m_age++;
    cyc++;
  endtask

  // Drive one cycle, compare against the reference, update it, advance the clock.
  task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic rst, output int g);
    int              eg;
    logic [NREQ-1:0] er;
    logic            ev;
    reset     = rst;
    req_valid = v;
    rsp_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
    end
    #1;
    eg = m_busy ? -1 : rr_pick(v, m_ptr);
    er = (eg < 0) ? '0 : (NREQ'(1) << eg);
    ev = m_busy && (m_age >= 3);
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) g = i;
    end
    if (rsp_valid) begin
      if (m_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_spurious: got id %0d data %h, expected no response (cycle %0d)", rsp_id, rsp_data, cyc);
      end else begin
        check("rsp_data", rsp_data, m_q[0].data);
        check("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
        check("rsp_cout", 32'(rsp_cout), 32'(m_q[0].cout));
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      m_q.delete();
      m_ptr  = 0;
    end else if (ev && rdy) begin
      void'(m_q.pop_front());
      m_busy = 1'b0;
    end else if (eg >= 0) begin
      m_q.push_back(ref_add(op_a[eg], op_b[eg], eg));
      m_busy    = 1'b1;
      m_age     = 0;
      m_ptr     = (eg + 1) % NREQ;
      op_a[eg]  = rand_op();
      op_b[eg]  = rand_op();
    end
    tick();
  endtask

  vec_t tbl[6];

  initial begin
    int              g, n, prev, exp_id, t0, cnt;
    logic [NREQ-1:0] pend;

    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'd0;
      op_b[i] = 32'd0;
    end
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_cout", 32'(rsp_cout), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    step(4'b0000, 1'b1, 1'b1, g);
    req_valid = 4'b1111;
    reset     = 1'b0;
    #1;
    check("reset_ptr_zero", 32'(req_ready), 32'd1);
    req_valid = 4'b0000;

    tbl[0] = '{0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
    tbl[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0002, SAT ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b1};
    tbl[2] = '{2, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
    tbl[3] = '{3, 32'h8000_0000, 32'h8000_0000, SAT ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1};
    tbl[4] = '{0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[5] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

    // Directed vectors: single requester, response expected exactly 3 cycles after grant.
    for (int k = 0; k < 6; k++) begin
      op_a[tbl[k].idx] = tbl[k].a;
      op_b[tbl[k].idx] = tbl[k].b;
      g = -1;
      for (int w = 0; w < 8 && g < 0; w++) step(NREQ'(1) << tbl[k].idx, 1'b1, 1'b0, g);
      check("tbl_grant", 32'(g), 32'(tbl[k].idx));
      step(4'b0000, 1'b1, 1'b0, g);
      step(4'b0000, 1'b1, 1'b0, g);
      check("tbl_valid", 32'(rsp_valid), 32'd1);
      check("tbl_data", rsp_data, tbl[k].exp_data);
      check("tbl_id", 32'(rsp_id), 32'(tbl[k].idx));
      check("tbl_cout", 32'(rsp_cout), 32'(tbl[k].exp_cout));
      step(4'b0000, 1'b1, 1'b0, g);
    end

    // Fairness: all requesters valid, ready tied high, ptr reset to 0.
    step(4'b0000, 1'b1, 1'b1, g);
    n = 0; prev = -1; exp_id = 0;
    for (int c = 0; c < 40; c++) begin
      t0 = cyc;
      step(4'b1111, 1'b1, 1'b0, g);
      if (g >= 0) begin
        check("fair_id", 32'(g), 32'(exp_id));
        exp_id = (exp_id + 1) % NREQ;
        if (prev >= 0) check("fair_gap", 32'(t0 - prev), 32'd4);
        prev = t0;
        n++;
      end
    end
    check("fair_count", 32'(n), 32'd10);
    repeat (6) step(4'b0000, 1'b1, 1'b0, g);

    // Backpressure: 10 stalled RSP cycles, no grants, then handshake; next grant only afterwards.
    step(4'b0010, 1'b0, 1'b0, g);
    check("bp_grant", 32'(g), 32'd1);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(4'b1111, 1'b0, 1'b0, g);
      if (g >= 0) cnt++;
    end
    check("bp_no_grant", 32'(cnt), 32'd0);
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    step(4'b1111, 1'b1, 1'b0, g);
    check("hs_cycle_no_grant", 32'(g), 32'hFFFF_FFFF);
    step(4'b1111, 1'b1, 1'b0, g);
    check("after_hs_grant", 32'(g), 32'd2);
    repeat (6) step(4'b0000, 1'b1, 1'b0, g);

    // Reset during HI: operation dropped, next grant from ptr=0.
    step(4'b0010, 1'b1, 1'b0, g);
    check("rst_hi_grant", 32'(g), 32'd1);
    step(4'b0000, 1'b1, 1'b0, g);
    step(4'b0000, 1'b1, 1'b1, g);
    step(4'b1010, 1'b1, 1'b0, g);
    check("rst_ptr_grant", 32'(g), 32'd1);
    repeat (6) step(4'b0000, 1'b1, 1'b0, g);

    // Withdrawn request: req2 valid for one RSP cycle only.
    step(4'b0001, 1'b0, 1'b0, g);
    step(4'b0000, 1'b0, 1'b0, g);
    step(4'b0000, 1'b0, 1'b0, g);
    step(4'b0100, 1'b0, 1'b0, g);
    step(4'b0000, 1'b0, 1'b0, g);
    step(4'b0000, 1'b1, 1'b0, g);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(4'b0000, 1'b1, 1'b0, g);
      if (g >= 0) cnt++;
    end
    check("withdraw_no_grant", 32'(cnt), 32'd0);

    // Randomized traffic with withdrawals and random backpressure.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = rand_op();
          op_b[i] = rand_op();
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end else begin
          pend[i] = pend[i];
        end
      end
      step(pend, $urandom_range(0, 3) != 0, 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    repeat (8) step(4'b0000, 1'b1, 1'b0, g);
    check("queue_drained", 32'(m_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add32_share_sched.md
# add32_share_sched

Scheduler that shares one 16-bit carry-select adder among `NREQ` requesters issuing 32-bit unsigned additions. Each operation is split into two adder passes: the low half first, then the high half with the registered carry. The block arbitrates requesters round-robin and returns a tagged result over a valid/ready response port. It sits between the requesting pipeline stages and the single `carry_select_adder_16bit` instance, replacing per-requester 32-bit adders.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: response tag width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept strobe.
- `req_a`  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  NREQ*32  operand B, same packing.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer ready.
- `rsp_data`  out  32  sum.
- `rsp_id`  out  IDW  index of the requester that issued the operation.
- `rsp_cout`  out  1  carry out of bit 31.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, grant one requester (round-robin), assert `req_ready[g]` for that cycle only, latch A, B and g, then go to LO. Otherwise stay in IDLE.
  - LO: adder gets `a[15:0]`, `b[15:0]`, cin=0. Register `sum[15:0]` and carry c16. Go to HI.
  - HI: adder gets `a[31:16]`, `b[31:16]`, cin=c16. Register `sum[31:16]` and cout. Go to RSP.
  - RSP: hold `rsp_valid`=1 with data, id and cout stable until `rsp_ready`=1. On the handshake cycle, drop to IDLE.
- Round-robin:
  - Pointer `ptr` marks the highest-priority index. Search from `ptr` upward, modulo NREQ.
  - After a grant to g, `ptr` becomes (g+1) mod NREQ.
  - `ptr` is not updated in cycles with no grant.
- `req_ready` is combinational from state, `req_valid` and `ptr`, and is one-hot or zero. It never asserts outside IDLE.
- Requesters hold `req_valid`, `req_a` and `req_b` stable until they see `req_ready`. Deasserting `req_valid` before the grant withdraws the request without error.
- Arithmetic is modulo 2^32. `rsp_cout` is the true carry out of the 32-bit add.
- The adder instance is driven only in LO and HI. In other states its inputs are zero.

## Timing
- Grant/accept in cycle t; LO in t+1; HI in t+2; `rsp_valid` rises in cycle t+3.
- Minimum issue interval is 4 cycles, reached when `rsp_ready` is tied high.
- Response backpressure stalls the FSM in RSP. No new grant is made while a response is pending.
- Reset values: state=IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_cout`=0. Internal operand and carry registers clear to 0.
- Reset asserted mid-operation (LO, HI or RSP) aborts the operation. The result is never presented, and the first cycle after reset deasserts is IDLE with `ptr`=0.
- Request arriving in the same cycle as the RSP handshake: it is not granted that cycle. It is considered in the following IDLE cycle.
- All `req_valid` high: grants cycle through ptr, ptr+1, … with no starvation. Each requester waits at most NREQ×4 cycles when `rsp_ready` is high.

## Configuration
- `ADD32_SHARE_SAT_EN`:
  - Defined: unsigned saturation. When the final carry is 1, `rsp_data`=32'hFFFF_FFFF and `rsp_cout`=1.
  - Undefined: wrap-around result as described in Operation.
- Latency and handshake are identical in both builds.

## Structure
- Shared package `add32_share_pkg`:
  - FSM state enum (IDLE, LO, HI, RSP).
  - Constants `HALF_W`=16 and `OP_W`=32.
- Sub-module `rr_grant`: NREQ-wide round-robin priority picker with inputs req and ptr, outputs one-hot grant and encoded index. It is purely combinational. `ptr` lives in the parent.
- The datapath reuses the existing `carry_select_adder_16bit`, with one instance only.

## Test plan
- Single request: req0 A=32'h0000_FFFF, B=32'h0000_0001 → `rsp_valid` at t+3; data=32'h0001_0000, id=0, cout=0. This checks the carry across halves.
- Overflow: A=32'hFFFF_FFFF, B=32'h0000_0002:
  - Without `ADD32_SHARE_SAT_EN`: data=32'h0000_0001, cout=1.
  - With it: data=32'hFFFF_FFFF, cout=1.
- Fairness: all 4 requesters valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0,…, one `req_ready` pulse every 4 cycles, ids in that order.
- Backpressure: hold `rsp_ready`=0 for 10 cycles during RSP → data, id and cout stable; `req_ready` stays 0 throughout; completes on the first `rsp_ready`=1.
- Reset in HI: assert `reset` for 1 cycle → no `rsp_valid` for that operation. The next grant goes to the lowest valid index (`ptr`=0).
- Withdrawn request: req2 valid for 1 cycle during RSP, then low → req2 is never granted and no spurious response appears.
